score_digit_scheduler: RTL and testbench

- Shares one iterative divide-by-10 digit extractor between two score sources: the live player score (source 0) and the high score (source 1).
- Schedules conversions from a periodic refresh tick and from explicit update requests. A round-robin arbiter selects the source to convert.
- Publishes per-source BCD digit vectors atomically to the seven-segment display drivers.
- Replaces free-running per-clock modulo chains with one sequenced, time-shared datapath.

---
 rtl/score_digit_scheduler.sv | 165 ++++++++++++++++
 tb/tb_score_digit_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_digit_scheduler.sv
// Time-shared decimal digit extractor for two score sources (player, high score).
// Round-robin scheduling from a refresh tick or requests; digits published atomically.
module score_digit_scheduler #(
  parameter int DIGITS         = 5,
  parameter int REFRESH_CYCLES = 50000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         score0,
  input  logic [31:0]         score1,
  input  logic [1:0]          req,
  output logic [4*DIGITS-1:0] digits0,
  output logic [4*DIGITS-1:0] digits1,
  output logic [1:0]          valid,
  output logic [1:0]          overflow,
  output logic                busy,
  output logic                done
);

  localparam int DW   = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW   = $clog2(REFRESH_CYCLES);

  function automatic logic [31:0] max_value(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int k = 0; k < n; k++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

  localparam logic [31:0]     MAX_VAL  = max_value(DIGITS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONVERT, S_COMMIT} state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [1:0]      pending_q, pending_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     work_q, work_d;
  logic [DW-1:0]   sr_q, sr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            ovf_q, ovf_d;
  logic [DW-1:0]   digits0_q, digits0_d;
  logic [DW-1:0]   digits1_q, digits1_d;
  logic [1:0]      valid_q, valid_d;
  logic [1:0]      ovf_out_q, ovf_out_d;

  logic            tick;
  logic [1:0]      clear;
  logic [31:0]     sel_score;
  logic [31:0]     quot;
  logic [3:0]      rem_digit;

  assign tick      = (cnt_q == CNT_LAST);
  assign sel_score = grant_q ? score1 : score0;
  assign quot      = work_q / 32'd10;
  assign rem_digit = 4'(work_q % 32'd10);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    work_d       = work_q;
    sr_d         = sr_q;
    idx_d        = idx_q;
    ovf_d        = ovf_q;
    digits0_d    = digits0_q;
    digits1_d    = digits1_q;
    valid_d      = valid_q;
    ovf_out_d    = ovf_out_q;
    clear        = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        if (pending_q != 2'b00) begin
          // With both pending, the source that did not win last time goes next
          grant_d      = (pending_q == 2'b11) ? ~last_grant_q : pending_q[1];
          last_grant_d = grant_d;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        clear[grant_q] = 1'b1;
        work_d         = sel_score;
        idx_d          = '0;
        if (sel_score > MAX_VAL) begin
          ovf_d = 1'b1;
          sr_d  = {DIGITS{4'h9}};
        end else begin
          ovf_d = 1'b0;
          sr_d  = '0;
        end
        state_d = S_CONVERT;
      end
      S_CONVERT: begin
        if (!ovf_q) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) sr_d[4*i +: 4] = rem_digit;
          end
          work_d = quot;
        end
        idx_d = idx_q + IDXW'(1);
        if (idx_q == IDX_LAST) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (grant_q) digits1_d = sr_q;
        else         digits0_d = sr_q;
        valid_d[grant_q]   = 1'b1;
        ovf_out_d[grant_q] = ovf_q;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A same-cycle set beats the LOAD clear
    pending_d = (pending_q & ~clear) | req | {2{tick}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      pending_q    <= 2'b00;
      cnt_q        <= '0;
      work_q       <= '0;
      sr_q         <= '0;
      idx_q        <= '0;
      ovf_q        <= 1'b0;
      digits0_q    <= '0;
      digits1_q    <= '0;
      valid_q      <= 2'b00;
      ovf_out_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      work_q       <= work_d;
      sr_q         <= sr_d;
      idx_q        <= idx_d;
      ovf_q        <= ovf_d;
      digits0_q    <= digits0_d;
      digits1_q    <= digits1_d;
      valid_q      <= valid_d;
      ovf_out_q    <= ovf_out_d;
    end
  end

  assign digits0  = digits0_q;
  assign digits1  = digits1_q;
  assign valid    = valid_q;
  assign overflow = ovf_out_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_COMMIT);

endmodule

// File: tb/tb_score_digit_scheduler.sv
// Bench for score_digit_scheduler: directed scenarios plus random traffic,
// compared every cycle against a transaction-level scheduling/decimal model.
module tb_score_digit_scheduler;

  localparam int D         = 5;
  localparam int R         = 16;
  localparam int COMMIT_PH = D + 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   score0, score1;
  logic [1:0]    req;
  logic [4*D-1:0] digits0, digits1;
  logic [1:0]    valid, overflow;
  logic          busy, done;

  score_digit_scheduler #(.DIGITS(D), .REFRESH_CYCLES(R)) dut (
    .clock(clock), .reset(reset), .score0(score0), .score1(score1), .req(req),
    .digits0(digits0), .digits1(digits1), .valid(valid), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Model: phase 0 idle, 1 load, 2..D+1 convert, D+2 commit
  int          m_ph, m_src, m_last, m_cnt;
  logic [1:0]  m_pend;
  logic [31:0] m_val;
  logic [4*D-1:0] m_dig [2];
  logic [1:0]  m_valid, m_ovf;

  int   t_load = 0;
  logic prev_busy = 1'b0;
  int   done_times[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input logic [31:0] v);
    logic [31:0]    t;
    logic [4*D-1:0] r;
    if (v > 32'd99999) return {D{4'h9}};
    t = v;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_src = 0; m_last = 1; m_cnt = 0; m_pend = 2'b00; m_val = '0;
    m_dig[0] = '0; m_dig[1] = '0; m_valid = 2'b00; m_ovf = 2'b00;
  endtask

  task automatic model_step();
    logic       tk;
    logic [1:0] clr;
    if (reset) begin
      model_reset();
      return;
    end
    tk    = (m_cnt == R - 1);
    m_cnt = tk ? 0 : m_cnt + 1;
    clr   = 2'b00;
    if (m_ph == 0) begin
      if (m_pend != 2'b00) begin
        if (m_pend == 2'b11) m_src = 1 - m_last;
        else                 m_src = m_pend[1] ? 1 : 0;
        m_last = m_src;
        m_ph   = 1;
      end
    end else if (m_ph == 1) begin
      m_val       = (m_src == 1) ? score1 : score0;
      clr[m_src]  = 1'b1;
      m_ph        = 2;
    end else if (m_ph == COMMIT_PH) begin
      m_dig[m_src]   = to_bcd(m_val);
      m_valid[m_src] = 1'b1;
      m_ovf[m_src]   = (m_val > 32'd99999);
      $display("cycle %0d: commit src%0d score=%0d digits=%h", cyc, m_src, m_val, m_dig[m_src]);
      m_ph = 0;
    end else begin
      m_ph++;
    end
    m_pend = (m_pend & ~clr) | req | {2{tk}};
  endtask

  task automatic compare_all();
    check("digits0", 32'(digits0), 32'(m_dig[0]));
    check("digits1", 32'(digits1), 32'(m_dig[1]));
    check("valid", 32'(valid), 32'(m_valid));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("busy", 32'(busy), 32'(m_ph != 0));
    check("done", 32'(done), 32'(m_ph == COMMIT_PH));
    if (busy && !prev_busy) t_load = cyc;
    if (done) begin
      check("latency", 32'(cyc - t_load), 32'(D + 1));
      done_times.push_back(cyc);
    end
    prev_busy = busy;
  endtask

  task automatic step_cycle();
    @(posedge clock);
    cyc++;
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic wait_commit(input int s, input int limit, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      step_cycle();
      if (m_ph == COMMIT_PH && m_src == s) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
    if (found) step_cycle();
  endtask

  task automatic wait_phase(input int ph, input int src, input int limit, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      step_cycle();
      if (m_ph == ph && (src < 0 || m_src == src)) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4*D-1:0] p0, p1;
    int             last, nev;
    bit             found;
    logic [31:0]    bnd [6];

    bnd = '{32'd0, 32'd9, 32'd99999, 32'd100000, 32'hFFFF_FFFF, 32'd10};

    // Reset release with a pending-free start; the first tick schedules both sources
    reset = 1'b1; req = 2'b00; score0 = 32'd12345; score1 = 32'd0;
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();
    reset = 1'b0;
    repeat (40) step_cycle();
    check("t1_digits0", 32'(digits0), 32'h12345);
    check("t1_digits1", 32'(digits1), 32'h00000);
    check("t1_valid", 32'(valid), 32'd3);
    if (done_times.size() >= 2)
      check("t1_done_gap", 32'(done_times[1] - done_times[0]), 32'd8);
    else
      check("t1_done_count", 32'(done_times.size()), 32'd2);

    // Immediate request for the high score
    score1 = 32'd907; req = 2'b10;
    step_cycle();
    req = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      if (busy) found = 1'b1;
      else      step_cycle();
    end
    check("t2_busy_after_req", 32'(found), 32'd1);
    wait_commit(1, 40, "t2_commit_src1");
    check("t2_digits1", 32'(digits1), 32'h00907);
    check("t2_digits0", 32'(digits0), 32'h12345);

    // Overflow saturates to all nines, then recovers
    score0 = 32'd123456; req = 2'b01;
    step_cycle();
    req = 2'b00;
    wait_commit(0, 40, "t3_commit_ovf");
    check("t3_digits0_ovf", 32'(digits0), 32'h99999);
    check("t3_overflow0", 32'(overflow[0]), 32'd1);
    score0 = 32'd42; req = 2'b01;
    step_cycle();
    req = 2'b00;
    wait_commit(0, 40, "t3_commit_42");
    check("t3_digits0_42", 32'(digits0), 32'h00042);
    check("t3_overflow0_clr", 32'(overflow[0]), 32'd0);

    // Both requests held: commits must alternate between sources
    req = 2'b11; p0 = digits0; p1 = digits1; last = -1; nev = 0;
    for (int i = 0; i < 40; i++) begin
      score0 = 32'(cyc);
      score1 = 32'(50000 + cyc);
      step_cycle();
      if (digits0 != p0) begin
        if (last >= 0) check("t4_alternate", 32'(last), 32'd1);
        last = 0; nev++;
      end
      if (digits1 != p1) begin
        if (last >= 0) check("t4_alternate", 32'(last), 32'd0);
        last = 1; nev++;
      end
      p0 = digits0; p1 = digits1;
    end
    req = 2'b00;
    check("t4_commit_count", 32'(nev >= 4), 32'd1);

    // Score change during CONVERT must not leak into the committed value
    score0 = 32'd555;
    repeat (20) step_cycle();
    req = 2'b01;
    step_cycle();
    req = 2'b00;
    wait_phase(3, 0, 40, "t5_reach_convert");
    score0 = 32'd777;
    wait_commit(0, 40, "t5_commit_555");
    check("t5_digits0_555", 32'(digits0), 32'h00555);
    req = 2'b01;
    step_cycle();
    req = 2'b00;
    wait_commit(0, 40, "t5_commit_777");
    check("t5_digits0_777", 32'(digits0), 32'h00777);

    // Reset during the third CONVERT cycle
    wait_phase(4, -1, 40, "t6_reach_convert3");
    reset = 1'b1;
    #1;
    check("t6_digits0_rst", 32'(digits0), 32'd0);
    check("t6_digits1_rst", 32'(digits1), 32'd0);
    check("t6_valid_rst", 32'(valid), 32'd0);
    check("t6_overflow_rst", 32'(overflow), 32'd0);
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_done_rst", 32'(done), 32'd0);
    model_reset();
    prev_busy = 1'b0;
    step_cycle();
    step_cycle();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step_cycle();
      check("t6_no_done_after_reset", 32'(done), 32'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      req = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: score0 = $urandom;
          1: score0 = bnd[$urandom_range(0, 5)];
          default: score0 = $urandom_range(0, 99999);
        endcase
      end
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: score1 = $urandom;
          1: score1 = bnd[$urandom_range(0, 5)];
          default: score1 = $urandom_range(0, 99999);
        endcase
      end
      step_cycle();
    end
    req = 2'b00;
    repeat (20) step_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
